// File: rtl/lcd_nibble_writer.sv
`default_nettype none
// ============================================================================
// lcd_nibble_writer : CPU write responder driving an HD44780 LCD on a 4-bit bus
// Revision          : 1.0
// ============================================================================

module lcd_nibble_writer #(
   parameter int unsigned POWERUP_CYC    = 750000,
   parameter int unsigned INIT_WAIT1_CYC = 205000,
   parameter int unsigned INIT_WAIT2_CYC = 5000,
   parameter int unsigned E_PULSE_CYC    = 12,
   parameter int unsigned NIBBLE_GAP_CYC = 50,
   parameter int unsigned CMD_WAIT_CYC   = 2000,
   parameter int unsigned CLEAR_WAIT_CYC = 82000
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       iWriteEnable,
   input  logic       iRS,
   input  logic [7:0] iData,
   output logic       oReady,
   output logic       oLCD_Enabled,
   output logic       oLCD_RS,
   output logic       oLCD_RW,
   output logic       oLCD_StrataFlashControl,
   output logic [3:0] oLCD_Data
);

   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   localparam int unsigned CNT_MAX = max2(POWERUP_CYC, max2(INIT_WAIT1_CYC,
                                     max2(INIT_WAIT2_CYC, max2(E_PULSE_CYC,
                                     max2(NIBBLE_GAP_CYC, max2(CMD_WAIT_CYC, CLEAR_WAIT_CYC))))));
   localparam int         CW       = $clog2(CNT_MAX + 1) < 2 ? 2 : $clog2(CNT_MAX + 1);
   localparam logic [3:0] SEQ_DONE = 4'd8;

   typedef enum logic [2:0] {
      S_PWR_WAIT = 3'd0,
      S_IDLE     = 3'd1,
      S_HI_SETUP = 3'd2,
      S_HI_E     = 3'd3,
      S_GAP      = 3'd4,
      S_LO_SETUP = 3'd5,
      S_LO_E     = 3'd6,
      S_SETTLE   = 3'd7
   } state_t;

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   r_last;
   logic [3:0]      r_seq;
   logic [3:0]      r_lo_nib;
   logic            r_nib_only;
   logic            r_arm;

   logic [7:0]      w_tab_byte;
   logic            w_tab_nib_only;
   logic [CW-1:0]   w_tab_last;
   logic            w_load_tab;

   function automatic logic [CW-1:0] settle_last(input logic rs, input logic [7:0] b);
      return (!rs && (b == 8'h01 || b == 8'h02)) ? CW'(CLEAR_WAIT_CYC - 1) : CW'(CMD_WAIT_CYC - 1);
   endfunction

   assign oLCD_RW                 = 1'b0;
   assign oLCD_StrataFlashControl = 1'b1;

   // r_seq 0..3 are the bare init nibbles, 4..7 the configuration bytes, 8 = user mode
   always_comb begin
      w_tab_byte     = 8'h00;
      w_tab_nib_only = 1'b0;
      w_tab_last     = '0;
      case (r_seq)
         4'd0: begin w_tab_byte = 8'h30; w_tab_nib_only = 1'b1; w_tab_last = CW'(INIT_WAIT1_CYC - 1); end
         4'd1: begin w_tab_byte = 8'h30; w_tab_nib_only = 1'b1; w_tab_last = CW'(INIT_WAIT2_CYC - 1); end
         4'd2: begin w_tab_byte = 8'h30; w_tab_nib_only = 1'b1; w_tab_last = CW'(CMD_WAIT_CYC - 1); end
         4'd3: begin w_tab_byte = 8'h20; w_tab_nib_only = 1'b1; w_tab_last = CW'(CMD_WAIT_CYC - 1); end
         4'd4: w_tab_byte = 8'h28;
         4'd5: w_tab_byte = 8'h06;
         4'd6: w_tab_byte = 8'h0C;
         4'd7: w_tab_byte = 8'h01;
         default: w_tab_byte = 8'h00;
      endcase
      if (!w_tab_nib_only) begin
         w_tab_last = settle_last(1'b0, w_tab_byte);
      end
   end

   assign w_load_tab = ((r_state == S_PWR_WAIT) && (r_cnt == CW'(POWERUP_CYC - 1))) ||
                       ((r_state == S_SETTLE) && (r_cnt == r_last) && (r_seq != SEQ_DONE));

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         r_state      <= S_PWR_WAIT;
         r_cnt        <= '0;
         r_last       <= '0;
         r_seq        <= '0;
         r_lo_nib     <= '0;
         r_nib_only   <= 1'b0;
         r_arm        <= 1'b1;
         oReady       <= 1'b0;
         oLCD_Enabled <= 1'b0;
         oLCD_RS      <= 1'b0;
         oLCD_Data    <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
         if (!iWriteEnable) begin
            r_arm <= 1'b1;
         end

         case (r_state)
            S_PWR_WAIT: ;
            S_IDLE: begin
               r_cnt <= '0;
               if (oReady && iWriteEnable && r_arm) begin
                  r_arm      <= 1'b0;
                  oReady     <= 1'b0;
                  oLCD_RS    <= iRS;
                  oLCD_Data  <= iData[7:4];
                  r_lo_nib   <= iData[3:0];
                  r_nib_only <= 1'b0;
                  r_last     <= settle_last(iRS, iData);
                  r_state    <= S_HI_SETUP;
               end
            end
            S_HI_SETUP: begin
               if (r_cnt == CW'(1)) begin
                  oLCD_Enabled <= 1'b1;
                  r_state      <= S_HI_E;
                  r_cnt        <= '0;
               end
            end
            S_HI_E: begin
               if (r_cnt == CW'(E_PULSE_CYC - 1)) begin
                  oLCD_Enabled <= 1'b0;
                  r_state      <= r_nib_only ? S_SETTLE : S_GAP;
                  r_cnt        <= '0;
               end
            end
            S_GAP: begin
               if (r_cnt == CW'(NIBBLE_GAP_CYC - 1)) begin
                  oLCD_Data <= r_lo_nib;
                  r_state   <= S_LO_SETUP;
                  r_cnt     <= '0;
               end
            end
            S_LO_SETUP: begin
               if (r_cnt == CW'(1)) begin
                  oLCD_Enabled <= 1'b1;
                  r_state      <= S_LO_E;
                  r_cnt        <= '0;
               end
            end
            S_LO_E: begin
               if (r_cnt == CW'(E_PULSE_CYC - 1)) begin
                  oLCD_Enabled <= 1'b0;
                  r_state      <= S_SETTLE;
                  r_cnt        <= '0;
               end
            end
            S_SETTLE: begin
               if ((r_cnt == r_last) && (r_seq == SEQ_DONE)) begin
                  oReady  <= 1'b1;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_PWR_WAIT;
         endcase

         if (w_load_tab) begin
            r_state    <= S_HI_SETUP;
            r_cnt      <= '0;
            r_seq      <= r_seq + 4'd1;
            oLCD_RS    <= 1'b0;
            oLCD_Data  <= w_tab_byte[7:4];
            r_lo_nib   <= w_tab_byte[3:0];
            r_nib_only <= w_tab_nib_only;
            r_last     <= w_tab_last;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_lcd_nibble_writer.sv
`default_nettype none
// ============================================================================
// tb_lcd_nibble_writer : bus-level checks of init sequence, writes and reset
// Revision             : 1.0
// ============================================================================

module tb_lcd_nibble_writer;

   localparam int PWR = 100;
   localparam int W1  = 40;
   localparam int W2  = 20;
   localparam int CMD = 10;
   localparam int CLR = 30;
   localparam int EP  = 3;
   localparam int GAP = 4;

   logic       Clock = 1'b0;
   logic       Reset = 1'b0;
   logic       iWriteEnable = 1'b0;
   logic       iRS = 1'b0;
   logic [7:0] iData = 8'h00;
   logic       oReady;
   logic       oLCD_Enabled;
   logic       oLCD_RS;
   logic       oLCD_RW;
   logic       oLCD_StrataFlashControl;
   logic [3:0] oLCD_Data;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   lcd_nibble_writer #(
      .POWERUP_CYC   (PWR),
      .INIT_WAIT1_CYC(W1),
      .INIT_WAIT2_CYC(W2),
      .E_PULSE_CYC   (EP),
      .NIBBLE_GAP_CYC(GAP),
      .CMD_WAIT_CYC  (CMD),
      .CLEAR_WAIT_CYC(CLR)
   ) dut (
      .Clock                  (Clock),
      .Reset                  (Reset),
      .iWriteEnable           (iWriteEnable),
      .iRS                    (iRS),
      .iData                  (iData),
      .oReady                 (oReady),
      .oLCD_Enabled           (oLCD_Enabled),
      .oLCD_RS                (oLCD_RS),
      .oLCD_RW                (oLCD_RW),
      .oLCD_StrataFlashControl(oLCD_StrataFlashControl),
      .oLCD_Data              (oLCD_Data)
   );

   always #5 Clock = ~Clock;
   always @(posedge Clock) cyc <= cyc + 1;

   // Bus monitor: one record per completed E pulse, with setup/hold observations
   typedef struct {
      logic [3:0] nib;
      logic       rs;
      int         width;
      int         rise;
      int         fall;
      bit         setup_ok;
      bit         stable_ok;
   } pulse_t;

   pulse_t     pq[$];
   pulse_t     cur;
   logic       prev_e = 1'b0;
   logic [3:0] hd1 = 4'h0, hd2 = 4'h0;
   logic       hr1 = 1'b0, hr2 = 1'b0;

   always @(negedge Clock) begin
      if (oLCD_Enabled === 1'b1 && prev_e !== 1'b1) begin
         cur.nib       = oLCD_Data;
         cur.rs        = oLCD_RS;
         cur.rise      = cyc;
         cur.width     = 0;
         cur.fall      = 0;
         cur.setup_ok  = (hd1 === oLCD_Data) && (hd2 === oLCD_Data) &&
                         (hr1 === oLCD_RS) && (hr2 === oLCD_RS);
         cur.stable_ok = 1'b1;
      end
      if (oLCD_Enabled === 1'b1) begin
         cur.width++;
         if (oLCD_Data !== cur.nib || oLCD_RS !== cur.rs) cur.stable_ok = 1'b0;
      end else if (prev_e === 1'b1) begin
         if (oLCD_Data !== cur.nib || oLCD_RS !== cur.rs) cur.stable_ok = 1'b0;
         cur.fall = cyc;
         pq.push_back(cur);
      end
      hd2    = hd1;
      hd1    = oLCD_Data;
      hr2    = hr1;
      hr1    = oLCD_RS;
      prev_e = oLCD_Enabled;
   end

   task automatic tick();
      @(negedge Clock);
      #1;
   endtask

   task automatic wait_ready(input int budget, output int rise_cyc, output bit ok);
      ok       = 1'b0;
      rise_cyc = -1;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (oReady === 1'b1) begin
            ok       = 1'b1;
            rise_cyc = cyc;
            break;
         end
      end
   endtask

   task automatic test_reset(output int rel);
      Reset        = 1'b0;
      iWriteEnable = 1'b0;
      repeat (3) tick();
      checks++; if (oReady !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b want=0", oReady); end
      checks++; if (oLCD_Enabled !== 1'b0) begin failures++; $display("FAIL reset_e got=%b want=0", oLCD_Enabled); end
      checks++; if (oLCD_RS !== 1'b0) begin failures++; $display("FAIL reset_rs got=%b want=0", oLCD_RS); end
      checks++; if (oLCD_Data !== 4'h0) begin failures++; $display("FAIL reset_data got=%h want=0", oLCD_Data); end
      checks++; if (oLCD_RW !== 1'b0) begin failures++; $display("FAIL reset_rw got=%b want=0", oLCD_RW); end
      checks++; if (oLCD_StrataFlashControl !== 1'b1) begin failures++; $display("FAIL reset_sf got=%b want=1", oLCD_StrataFlashControl); end
      Reset = 1'b1;
      rel   = cyc;
      pq.delete();
   endtask

   // rel = label of the last sampled cycle whose edge still had Reset low
   task automatic test_init(input int rel);
      logic [7:0]  cfg[4];
      logic [3:0]  exp_nib[$];
      int          exp_gap[$];
      int          rdy;
      bit          ok;
      int          n;
      bit          gaps_ok;
      cfg = '{8'h28, 8'h06, 8'h0C, 8'h01};
      exp_nib = '{4'h3, 4'h3, 4'h3, 4'h2};
      exp_gap = '{W1, W2, CMD, CMD};
      for (int i = 0; i < 4; i++) begin
         exp_nib.push_back(cfg[i][7:4]);
         exp_nib.push_back(cfg[i][3:0]);
         exp_gap.push_back(GAP);
         if (i < 3) exp_gap.push_back((cfg[i] == 8'h01 || cfg[i] == 8'h02) ? CLR : CMD);
      end
      wait_ready(3000, rdy, ok);
      checks++; if (!ok) begin failures++; $display("FAIL init_ready_timeout got=0 want=1"); end
      checks++; if (pq.size() != 12) begin failures++; $display("FAIL init_count got=%0d want=12", pq.size()); end
      n = (pq.size() < 12) ? pq.size() : 12;
      for (int i = 0; i < n; i++) begin
         checks++;
         if (pq[i].nib !== exp_nib[i] || pq[i].rs !== 1'b0 || pq[i].width != EP ||
             !pq[i].setup_ok || !pq[i].stable_ok) begin
            failures++;
            $display("FAIL init_nibble[%0d] got=%h rs=%b w=%0d su=%0d st=%0d want=%h rs=0 w=%0d su=1 st=1",
                     i, pq[i].nib, pq[i].rs, pq[i].width, pq[i].setup_ok, pq[i].stable_ok, exp_nib[i], EP);
         end
      end
      if (n > 0) begin
         checks++;
         if (pq[0].rise != rel + PWR + 2) begin
            failures++; $display("FAIL init_first_rise got=%0d want=%0d", pq[0].rise, rel + PWR + 2);
         end
      end
      if (n == 12) begin
         gaps_ok = 1'b1;
         for (int i = 0; i < 11; i++)
            if (pq[i+1].rise - pq[i].fall != exp_gap[i] + 2) gaps_ok = 1'b0;
         checks++; if (!gaps_ok) begin failures++; $display("FAIL init_gaps got=bad want=per-step waits"); end
         checks++;
         if (rdy - pq[11].fall != CLR) begin
            failures++; $display("FAIL init_clear_wait got=%0d want=%0d", rdy - pq[11].fall, CLR);
         end
      end
   endtask

   task automatic test_write(input logic rs, input logic [7:0] data);
      int c, rdy, w, lo_rise;
      bit ok;
      iWriteEnable = 1'b0;
      tick();
      pq.delete();
      c            = cyc;
      iWriteEnable = 1'b1;
      iRS          = rs;
      iData        = data;
      tick();
      checks++; if (oReady !== 1'b0) begin failures++; $display("FAIL wr_ready_fall got=%b want=0 data=%h", oReady, data); end
      iWriteEnable = 1'b0;
      wait_ready(500, rdy, ok);
      w       = (!rs && (data == 8'h01 || data == 8'h02)) ? CLR : CMD;
      lo_rise = c + 3 + EP + GAP + 2;
      checks++; if (!ok) begin failures++; $display("FAIL wr_timeout got=0 want=1 data=%h", data); end
      checks++; if (pq.size() != 2) begin failures++; $display("FAIL wr_count got=%0d want=2 data=%h", pq.size(), data); end
      if (pq.size() == 2) begin
         checks++;
         if (pq[0].nib !== data[7:4] || pq[0].rs !== rs || pq[0].width != EP || pq[0].rise != c + 3 ||
             !pq[0].setup_ok || !pq[0].stable_ok) begin
            failures++;
            $display("FAIL wr_hi got=%h rs=%b w=%0d rise=%0d want=%h rs=%b w=%0d rise=%0d",
                     pq[0].nib, pq[0].rs, pq[0].width, pq[0].rise, data[7:4], rs, EP, c + 3);
         end
         checks++;
         if (pq[1].nib !== data[3:0] || pq[1].rs !== rs || pq[1].width != EP || pq[1].rise != lo_rise ||
             !pq[1].setup_ok || !pq[1].stable_ok) begin
            failures++;
            $display("FAIL wr_lo got=%h rs=%b w=%0d rise=%0d want=%h rs=%b w=%0d rise=%0d",
                     pq[1].nib, pq[1].rs, pq[1].width, pq[1].rise, data[3:0], rs, EP, lo_rise);
         end
      end
      checks++;
      if (rdy != lo_rise + EP + w) begin
         failures++; $display("FAIL wr_ready_rise got=%0d want=%0d data=%h rs=%b", rdy, lo_rise + EP + w, data, rs);
      end
   endtask

   task automatic test_random();
      logic       rs;
      logic [7:0] d;
      for (int i = 0; i < 8; i++) begin
         rs = 1'($urandom_range(0, 1));
         d  = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 3) == 0) d = 8'($urandom_range(1, 2));
         test_write(rs, d);
      end
   endtask

   task automatic test_hold_level();
      int rdy;
      bit ok;
      iWriteEnable = 1'b0;
      tick();
      pq.delete();
      iWriteEnable = 1'b1;
      iRS          = 1'b1;
      iData        = 8'h48;
      repeat (200) tick();
      checks++; if (pq.size() != 2) begin failures++; $display("FAIL hold_count got=%0d want=2", pq.size()); end
      if (pq.size() >= 2) begin
         checks++;
         if (pq[0].nib !== 4'h4 || pq[1].nib !== 4'h8) begin
            failures++; $display("FAIL hold_nibbles got=%h%h want=48", pq[0].nib, pq[1].nib);
         end
      end
      checks++; if (oReady !== 1'b1) begin failures++; $display("FAIL hold_ready got=%b want=1", oReady); end
      iWriteEnable = 1'b0;
      tick();
      iWriteEnable = 1'b1;
      tick();
      checks++; if (oReady !== 1'b0) begin failures++; $display("FAIL hold_rearm got=%b want=0", oReady); end
      iWriteEnable = 1'b0;
      wait_ready(500, rdy, ok);
      checks++; if (pq.size() != 4) begin failures++; $display("FAIL hold_second_count got=%0d want=4", pq.size()); end
   endtask

   task automatic test_ignored();
      int rdy;
      bit ok;
      iWriteEnable = 1'b0;
      tick();
      pq.delete();
      iWriteEnable = 1'b1;
      iRS          = 1'b1;
      iData        = 8'hA3;
      tick();
      iWriteEnable = 1'b0;
      repeat (4) tick();
      iWriteEnable = 1'b1;
      iData        = 8'h55;
      tick();
      iWriteEnable = 1'b0;
      iData        = 8'h00;
      wait_ready(500, rdy, ok);
      repeat (30) tick();
      checks++; if (pq.size() != 2) begin failures++; $display("FAIL ignored_count got=%0d want=2", pq.size()); end
      if (pq.size() >= 2) begin
         checks++;
         if (pq[0].nib !== 4'hA || pq[1].nib !== 4'h3) begin
            failures++; $display("FAIL ignored_nibbles got=%h%h want=a3", pq[0].nib, pq[1].nib);
         end
      end
      checks++; if (oReady !== 1'b1) begin failures++; $display("FAIL ignored_ready got=%b want=1", oReady); end
   endtask

   task automatic test_reset_mid();
      bit found;
      int rel;
      iWriteEnable = 1'b0;
      tick();
      pq.delete();
      iWriteEnable = 1'b1;
      iRS          = 1'b1;
      iData        = 8'h5A;
      tick();
      iWriteEnable = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (pq.size() == 1 && oLCD_Enabled === 1'b1) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      checks++; if (!found) begin failures++; $display("FAIL rstmid_lo_e got=0 want=1"); end
      Reset = 1'b0;
      tick();
      checks++; if (oLCD_Enabled !== 1'b0) begin failures++; $display("FAIL rstmid_e got=%b want=0", oLCD_Enabled); end
      checks++; if (oReady !== 1'b0) begin failures++; $display("FAIL rstmid_ready got=%b want=0", oReady); end
      Reset = 1'b1;
      rel   = cyc;
      pq.delete();
      test_init(rel);
   endtask

   initial begin
      int rel;
      test_reset(rel);
      test_init(rel);
      test_write(1'b1, 8'h41);
      test_write(1'b0, 8'h01);
      test_write(1'b1, 8'h01);
      test_write(1'b0, 8'h02);
      test_random();
      test_hold_level();
      test_ignored();
      test_reset_mid();
      test_write(1'b1, 8'h7E);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got=running want=finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire

// File: doc/lcd_nibble_writer.md
Name: lcd_nibble_writer

Overview:
- Responder end of the CPU-to-LCD write interface. The MiniAlu `LCD` instruction raises a write strobe with a byte; this block accepts it and drives the Spartan-3E character LCD over its 4-bit bus.
- After reset it runs the power-on init and configuration sequence autonomously, then accepts one byte (command or data) per handshake.
- Each byte is split into two nibble strobes with HD44780 timing, followed by a settle wait.

Parameters:
- POWERUP_CYC, 750000, wait after reset before first init nibble (15 ms at 50 MHz)
- INIT_WAIT1_CYC, 205000, wait after 1st init nibble (4.1 ms)
- INIT_WAIT2_CYC, 5000, wait after 2nd init nibble (100 us)
- E_PULSE_CYC, 12, cycles E held high per nibble
- NIBBLE_GAP_CYC, 50, E-low cycles between high and low nibble (1 us)
- CMD_WAIT_CYC, 2000, settle after byte or after 3rd/4th init nibble (40 us)
- CLEAR_WAIT_CYC, 82000, settle after command 0x01 or 0x02 (1.64 ms)

Ports:
- Clock  in  1  system clock, 50 MHz
- Reset  in  1  synchronous, active-low; Reset==0 at a rising edge resets the block
- iWriteEnable  in  1  write request, level from CPU decode
- iRS  in  1  0 = command, 1 = character data
- iData  in  8  byte to write
- oReady  out  1  high = idle and able to accept
- oLCD_Enabled  out  1  LCD E
- oLCD_RS  out  1  LCD RS
- oLCD_RW  out  1  LCD RW, constant 0
- oLCD_StrataFlashControl  out  1  SF_CE0, constant 1 (flash disabled)
- oLCD_Data  out  4  LCD DB[7:4]

Behaviour:
- Reset (Reset==0 at a clock edge), required values the following cycle:
  - oReady=0, oLCD_Enabled=0, oLCD_RS=0, oLCD_Data=0, RW=0, SF_CE0=1
  - state=S_PWR_WAIT, counters cleared, arm flag set
- Reset mid-operation aborts the current transaction immediately and restarts the full init. Any E pulse in progress drops the next cycle.
- Nibble strobe primitive:
  - RS and data are presented 2 cycles before E rises.
  - E is high for E_PULSE_CYC cycles, then low.
  - RS and data are held 1 cycle after E falls.
- States: S_PWR_WAIT -> S_INIT (4 nibbles) -> S_CFG (4 bytes) -> S_IDLE <-> S_WRITE (S_HI_SETUP, S_HI_E, S_GAP, S_LO_SETUP, S_LO_E, S_SETTLE).
- S_PWR_WAIT: count POWERUP_CYC.
- S_INIT: strobe nibbles with RS=0, each followed by its wait:
  - 0x3, then INIT_WAIT1_CYC
  - 0x3, then INIT_WAIT2_CYC
  - 0x3, then CMD_WAIT_CYC
  - 0x2, then CMD_WAIT_CYC
- S_CFG: full byte writes with RS=0, in order 0x28, 0x06, 0x0C, 0x01. The 0x01 settle uses CLEAR_WAIT_CYC.
- S_IDLE: oReady=1.
- Accept condition: oReady=1, iWriteEnable=1, arm=1, all in the same cycle (cycle T). On accept, latch iData and iRS and clear arm.
- Arm is set again only in a cycle where iWriteEnable=0. A level held across a whole transaction therefore produces exactly one write.
- Requests while oReady=0 are ignored and not queued.
- Write timing from accept at cycle T (defaults):
  - T+1: oReady=0, RS=latched iRS, data=iData[7:4]
  - E high T+3 .. T+14
  - gap T+15 .. T+64
  - T+65: data=iData[3:0]
  - E high T+67 .. T+78
  - settle T+79 .. T+2078
  - T+2079: oReady=1
- Settle length is CLEAR_WAIT_CYC when iRS=0 and the byte is 0x01 or 0x02; otherwise CMD_WAIT_CYC.
- Accept can recur at T+2079 at the earliest (requires the arm to have been re-armed).
- Counters are wide enough for the largest parameter; no wrap before terminal count. All timing is counted in Clock cycles, with no dependence on the busy flag (RW is never 1).

Test Plan (sim parameters: POWERUP_CYC=100, INIT_WAIT1_CYC=40, INIT_WAIT2_CYC=20, CMD_WAIT_CYC=10, CLEAR_WAIT_CYC=30, E_PULSE_CYC=3, NIBBLE_GAP_CYC=4):
- Release reset and wait -> outputs stay at reset values for 100 cycles. Then E pulses carry nibbles 3,3,3,2, then 2,8,0,6,0,C,0,1, all with RS=0. oReady rises only after the final 30-cycle clear wait.
- Idle; pulse iWriteEnable one cycle with iRS=1, iData=0x41 -> oReady falls at T+1. Exactly two E pulses of 3 cycles carrying 0x4 then 0x1 with RS=1. oReady returns high after the 10-cycle settle.
- Hold iWriteEnable=1 with iData=0x48 for 200 cycles -> exactly one write. No second write until iWriteEnable has been low at least one cycle.
- Assert iWriteEnable with 0x55 mid-transaction -> ignored. The bus shows only the first byte's nibbles.
- Write iRS=0, iData=0x01 -> settle uses 30 cycles, not 10. Write iRS=1, 0x01 -> 10 cycles.
- Drive Reset=0 during the E-high of a low nibble -> E=0 and oReady=0 the next cycle. The full init sequence replays.
